// File: rtl/addr_mode_decoder.sv
// addr_mode_decoder: registered 6502 opcode addressing-mode, effective-address and class decode.
module addr_mode_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode,
    input  logic [15:0] pc,
    input  logic [7:0]  operand1,
    input  logic [7:0]  operand2,
    input  logic [7:0]  reg_x,
    input  logic [7:0]  reg_y,
    output logic [15:0] effective_addr,
    output logic [2:0]  addr_mode,
    output logic [1:0]  instruction_length,
    output logic        page_crossed,
    output logic        is_load,
    output logic        is_store,
    output logic        is_arithmetic,
    output logic        is_logical,
    output logic        is_shift,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_transfer,
    output logic        is_compare,
    output logic        is_flag,
    output logic        is_stack,
    output logic        use_reg_a,
    output logic        use_reg_x,
    output logic        use_reg_y,
    output logic        affects_n,
    output logic        affects_z,
    output logic        affects_c,
    output logic        affects_v,
    output logic        mem_read,
    output logic        mem_write
);
    typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ZPIDX, M_ABS, M_ABSIDX, M_IND, M_REL} mode_e;
    typedef enum logic [3:0] {
        C_NONE, C_LOAD, C_STORE, C_ARITH, C_LOGIC, C_SHIFT, C_BRANCH,
        C_JUMP, C_TRANSFER, C_COMPARE, C_FLAG, C_STACK
    } class_e;
    typedef struct packed {
        logic [15:0] ea;
        mode_e       mode;
        logic [1:0]  len;
        logic        pcx;
        class_e      cls;
        logic        use_a, use_x, use_y, n, z, c, v, rd, wr;
    } out_t;
    localparam logic [23:0] MODES01 = {M_ABSIDX, M_ABSIDX, M_ZPIDX, M_IND, M_ABS, M_IMM, M_ZP, M_IND};
    localparam logic [23:0] MODES10 = {M_ABSIDX, M_IMP, M_ZPIDX, M_IMP, M_ABS, M_IMP, M_ZP, M_IMM};
    localparam logic [23:0] MODES00 = {M_ABSIDX, M_IMP, M_ZPIDX, M_REL, M_ABS, M_IMP, M_ZP, M_IMP};
    logic [1:0]  cc;
    logic [2:0]  aaa, bbb;
    logic        valid, idx_y, ix_mode, mem_mode, adc_sbc;
    class_e      cls;
    mode_e       mode;
    logic [7:0]  idx, zp_idx;
    logic [8:0]  lo_sum;
    logic [15:0] abs_idx, pc2, rel;
    out_t        out_d, out_q;
    assign cc  = opcode[1:0];
    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    always_comb begin
        cls   = C_NONE;
        valid = 1'b1;
        if (cc == 2'b01) begin
            valid = opcode != 8'h89;
            cls   = !valid ? C_NONE : aaa == 3'd4 ? C_STORE : aaa == 3'd5 ? C_LOAD :
                    aaa == 3'd6 ? C_COMPARE : aaa[1:0] == 2'b11 ? C_ARITH : C_LOGIC;
        end else begin
            casez (opcode)
                8'h84, 8'h8C, 8'h94, 8'h86, 8'h8E, 8'h96: cls = C_STORE;
                8'hA2, 8'hA6, 8'hAE, 8'hB6, 8'hBE, 8'hA0, 8'hA4, 8'hAC, 8'hB4, 8'hBC: cls = C_LOAD;
                8'hC0, 8'hC4, 8'hCC, 8'hE0, 8'hE4, 8'hEC: cls = C_COMPARE;
                8'hCA, 8'h88, 8'hC8, 8'hE8, 8'b11???110: cls = C_ARITH;
                8'h24, 8'h2C: cls = C_LOGIC;
                8'b0??01010, 8'b0????110: cls = C_SHIFT;
                8'b???10000: cls = C_BRANCH;
                8'h00, 8'h20, 8'h40, 8'h60, 8'h4C, 8'h6C: cls = C_JUMP;
                8'h8A, 8'h9A, 8'hAA, 8'hBA, 8'h98, 8'hA8: cls = C_TRANSFER;
                8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hD8, 8'hF8: cls = C_FLAG;
                8'h08, 8'h28, 8'h48, 8'h68: cls = C_STACK;
                8'hEA: cls = C_NONE;
                default: valid = 1'b0;
            endcase
        end
    end
    assign mode = !valid ? M_IMP :
                  opcode inside {8'hA0, 8'hC0, 8'hE0} ? M_IMM :
                  opcode == 8'h20 ? M_ABS :
                  opcode == 8'h6C ? M_IND :
                  mode_e'(cc == 2'b01 ? MODES01[bbb*3 +: 3] :
                          cc == 2'b10 ? MODES10[bbb*3 +: 3] : MODES00[bbb*3 +: 3]);
    assign idx_y    = cc == 2'b01 ? (bbb == 3'd4 || bbb == 3'd6) : opcode inside {8'h96, 8'hB6, 8'hBE};
    assign ix_mode  = mode inside {M_ZPIDX, M_ABSIDX} || (mode == M_IND && cc == 2'b01);
    assign mem_mode = !(mode inside {M_IMP, M_IMM, M_REL});
    assign adc_sbc  = valid && cc == 2'b01 && opcode[6:5] == 2'b11;
    assign idx      = idx_y ? reg_y : reg_x;
    assign zp_idx   = operand1 + idx;
    assign lo_sum   = {1'b0, operand1} + {1'b0, idx};
    assign abs_idx  = {operand2, operand1} + {8'h00, idx};
    assign pc2      = pc + 16'd2;
    assign rel      = pc2 + {{8{operand1[7]}}, operand1};
    always_comb begin
        out_d       = '0;
        out_d.mode  = mode;
        out_d.cls   = cls;
        out_d.ea    = mode == M_IMM    ? pc + 16'd1 :
                      mode == M_ZP     ? {8'h00, operand1} :
                      mode == M_ZPIDX  ? {8'h00, zp_idx} :
                      mode == M_ABS    ? {operand2, operand1} :
                      mode == M_ABSIDX ? abs_idx :
                      mode == M_REL    ? rel :
                      mode == M_IND    ? (opcode == 8'h6C ? {operand2, operand1} :
                                          bbb == 3'd0 ? {8'h00, zp_idx} : {8'h00, operand1}) : 16'h0000;
        out_d.len   = mode == M_IMP ? 2'd1 :
                      (mode inside {M_ABS, M_ABSIDX} || opcode == 8'h6C) ? 2'd3 : 2'd2;
        out_d.pcx   = mode == M_ABSIDX ? lo_sum[8] : mode == M_REL && pc2[15:8] != rel[15:8];
        out_d.use_a = (valid && cc == 2'b01) ||
                      opcode inside {8'h24, 8'h2C, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h48, 8'h68,
                                     8'h0A, 8'h2A, 8'h4A, 8'h6A};
        out_d.use_x = (ix_mode && !idx_y) ||
                      opcode inside {8'hA2, 8'hA6, 8'hAE, 8'hB6, 8'hBE, 8'hAA, 8'hBA, 8'h86, 8'h8E,
                                     8'h96, 8'h8A, 8'h9A, 8'hE0, 8'hE4, 8'hEC, 8'hE8, 8'hCA};
        out_d.use_y = (ix_mode && idx_y) ||
                      opcode inside {8'hA0, 8'hA4, 8'hAC, 8'hB4, 8'hBC, 8'hA8, 8'h84, 8'h8C,
                                     8'h94, 8'h88, 8'h98, 8'hC0, 8'hC4, 8'hCC, 8'hC8};
        out_d.n     = cls inside {C_LOAD, C_ARITH, C_LOGIC, C_SHIFT, C_COMPARE} ||
                      (cls == C_TRANSFER && opcode != 8'h9A) || opcode inside {8'h68, 8'h28, 8'h40};
        out_d.z     = out_d.n;
        out_d.c     = adc_sbc || cls inside {C_SHIFT, C_COMPARE} || opcode inside {8'h18, 8'h38, 8'h28, 8'h40};
        out_d.v     = adc_sbc || opcode inside {8'h24, 8'h2C, 8'hB8, 8'h28, 8'h40};
        out_d.rd    = mem_mode && cls inside {C_LOAD, C_LOGIC, C_COMPARE, C_ARITH, C_SHIFT};
        out_d.wr    = mem_mode && (cls == C_STORE || (cls inside {C_SHIFT, C_ARITH} && cc == 2'b10));
    end
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end
    assign effective_addr     = out_q.ea;
    assign addr_mode          = out_q.mode;
    assign instruction_length = out_q.len;
    assign page_crossed       = out_q.pcx;
    assign is_load            = out_q.cls == C_LOAD;
    assign is_store           = out_q.cls == C_STORE;
    assign is_arithmetic      = out_q.cls == C_ARITH;
    assign is_logical         = out_q.cls == C_LOGIC;
    assign is_shift           = out_q.cls == C_SHIFT;
    assign is_branch          = out_q.cls == C_BRANCH;
    assign is_jump            = out_q.cls == C_JUMP;
    assign is_transfer        = out_q.cls == C_TRANSFER;
    assign is_compare         = out_q.cls == C_COMPARE;
    assign is_flag            = out_q.cls == C_FLAG;
    assign is_stack           = out_q.cls == C_STACK;
    assign use_reg_a          = out_q.use_a;
    assign use_reg_x          = out_q.use_x;
    assign use_reg_y          = out_q.use_y;
    assign affects_n          = out_q.n;
    assign affects_z          = out_q.z;
    assign affects_c          = out_q.c;
    assign affects_v          = out_q.v;
    assign mem_read           = out_q.rd;
    assign mem_write          = out_q.wr;
endmodule

// File: tb/tb_addr_mode_decoder.sv
// tb_addr_mode_decoder: directed-vector bench with immediate assertions for addr_mode_decoder.
module tb_addr_mode_decoder;
    localparam logic [10:0] LD = 11'h400, ST = 11'h200, AR = 11'h100, LG = 11'h080, SH = 11'h040,
                            BR = 11'h020, JP = 11'h010, TR = 11'h008, CP = 11'h004, FL = 11'h002,
                            SK = 11'h001, NO = 11'h000;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  opcode, operand1, operand2, reg_x, reg_y;
    logic [15:0] pc;
    logic [15:0] effective_addr;
    logic [2:0]  addr_mode;
    logic [1:0]  instruction_length;
    logic        page_crossed;
    logic        is_load, is_store, is_arithmetic, is_logical, is_shift, is_branch, is_jump;
    logic        is_transfer, is_compare, is_flag, is_stack;
    logic        use_reg_a, use_reg_x, use_reg_y;
    logic        affects_n, affects_z, affects_c, affects_v, mem_read, mem_write;
    logic [41:0] obs;
    int          checks = 0;
    int          failures = 0;

    addr_mode_decoder dut (
        .clk(clk), .rst(rst), .opcode(opcode), .pc(pc), .operand1(operand1), .operand2(operand2),
        .reg_x(reg_x), .reg_y(reg_y), .effective_addr(effective_addr), .addr_mode(addr_mode),
        .instruction_length(instruction_length), .page_crossed(page_crossed),
        .is_load(is_load), .is_store(is_store), .is_arithmetic(is_arithmetic),
        .is_logical(is_logical), .is_shift(is_shift), .is_branch(is_branch), .is_jump(is_jump),
        .is_transfer(is_transfer), .is_compare(is_compare), .is_flag(is_flag), .is_stack(is_stack),
        .use_reg_a(use_reg_a), .use_reg_x(use_reg_x), .use_reg_y(use_reg_y),
        .affects_n(affects_n), .affects_z(affects_z), .affects_c(affects_c), .affects_v(affects_v),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    assign obs = {effective_addr, addr_mode, instruction_length, page_crossed,
                  is_load, is_store, is_arithmetic, is_logical, is_shift, is_branch, is_jump,
                  is_transfer, is_compare, is_flag, is_stack, use_reg_a, use_reg_x, use_reg_y,
                  affects_n, affects_z, affects_c, affects_v, mem_read, mem_write};

    function automatic logic [41:0] ev(input logic [15:0] ea, input logic [2:0] m, input logic [1:0] l,
                                       input logic px, input logic [10:0] c, input logic [2:0] u,
                                       input logic [3:0] f, input logic [1:0] mm);
        return {ea, m, l, px, c, u, f, mm};
    endfunction

    task automatic step(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2);
        opcode = op;
        operand1 = o1;
        operand2 = o2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [41:0] e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        pc = 16'h0200;
        reg_x = 8'h05;
        reg_y = 8'h03;
        step(8'hA9, 8'h55, 8'h00);
        chk("reset_init", '0);
        rst = 1'b0;
        step(8'hA9, 8'h55, 8'h00);
        chk("lda_imm", ev(16'h0201, 3'd1, 2'd2, 1'b0, LD, 3'b100, 4'b1100, 2'b00));
        step(8'hA9, 8'h55, 8'h00);
        chk("lda_imm_hold", ev(16'h0201, 3'd1, 2'd2, 1'b0, LD, 3'b100, 4'b1100, 2'b00));
        step(8'hB5, 8'h80, 8'h00);
        chk("lda_zpx", ev(16'h0085, 3'd3, 2'd2, 1'b0, LD, 3'b110, 4'b1100, 2'b10));
        step(8'hA1, 8'hFB, 8'h00);
        chk("lda_indx_wrap", ev(16'h0000, 3'd6, 2'd2, 1'b0, LD, 3'b110, 4'b1100, 2'b10));
        step(8'hBD, 8'h34, 8'h12);
        chk("lda_absx", ev(16'h1239, 3'd5, 2'd3, 1'b0, LD, 3'b110, 4'b1100, 2'b10));
        step(8'hBD, 8'hFE, 8'h12);
        chk("lda_absx_cross", ev(16'h1303, 3'd5, 2'd3, 1'b1, LD, 3'b110, 4'b1100, 2'b10));
        step(8'h10, 8'h05, 8'h00);
        chk("bpl_fwd", ev(16'h0207, 3'd7, 2'd2, 1'b0, BR, 3'b000, 4'b0000, 2'b00));
        step(8'hD0, 8'hFB, 8'h00);
        chk("bne_back_cross", ev(16'h01FD, 3'd7, 2'd2, 1'b1, BR, 3'b000, 4'b0000, 2'b00));
        step(8'h8D, 8'h56, 8'h34);
        chk("sta_abs", ev(16'h3456, 3'd4, 2'd3, 1'b0, ST, 3'b100, 4'b0000, 2'b01));
        step(8'hEA, 8'h00, 8'h00);
        chk("nop", ev(16'h0000, 3'd0, 2'd1, 1'b0, NO, 3'b000, 4'b0000, 2'b00));
        step(8'h02, 8'h12, 8'h34);
        chk("undef_02", ev(16'h0000, 3'd0, 2'd1, 1'b0, NO, 3'b000, 4'b0000, 2'b00));
        step(8'h89, 8'h12, 8'h34);
        chk("undef_89", ev(16'h0000, 3'd0, 2'd1, 1'b0, NO, 3'b000, 4'b0000, 2'b00));
        step(8'hB6, 8'h10, 8'h00);
        chk("ldx_zpy", ev(16'h0013, 3'd3, 2'd2, 1'b0, LD, 3'b011, 4'b1100, 2'b10));
        step(8'hFE, 8'hFE, 8'h12);
        chk("inc_absx_rmw", ev(16'h1303, 3'd5, 2'd3, 1'b1, AR, 3'b010, 4'b1100, 2'b11));
        step(8'h6C, 8'h00, 8'h30);
        chk("jmp_ind", ev(16'h3000, 3'd6, 2'd3, 1'b0, JP, 3'b000, 4'b0000, 2'b00));
        step(8'h0A, 8'h00, 8'h00);
        chk("asl_acc", ev(16'h0000, 3'd0, 2'd1, 1'b0, SH, 3'b100, 4'b1110, 2'b00));
        step(8'h69, 8'h10, 8'h00);
        chk("adc_imm", ev(16'h0201, 3'd1, 2'd2, 1'b0, AR, 3'b100, 4'b1111, 2'b00));
        step(8'h28, 8'h00, 8'h00);
        chk("plp", ev(16'h0000, 3'd0, 2'd1, 1'b0, SK, 3'b000, 4'b1111, 2'b00));
        step(8'h91, 8'h20, 8'h00);
        chk("sta_indy", ev(16'h0020, 3'd6, 2'd2, 1'b0, ST, 3'b101, 4'b0000, 2'b01));
        step(8'h00, 8'h00, 8'h00);
        chk("brk", ev(16'h0000, 3'd0, 2'd1, 1'b0, JP, 3'b000, 4'b0000, 2'b00));
        step(8'hCC, 8'h00, 8'h40);
        chk("cpy_abs", ev(16'h4000, 3'd4, 2'd3, 1'b0, CP, 3'b001, 4'b1110, 2'b10));
        step(8'h9A, 8'h00, 8'h00);
        chk("txs", ev(16'h0000, 3'd0, 2'd1, 1'b0, TR, 3'b010, 4'b0000, 2'b00));
        step(8'hB8, 8'h00, 8'h00);
        chk("clv", ev(16'h0000, 3'd0, 2'd1, 1'b0, FL, 3'b000, 4'b0001, 2'b00));
        step(8'h2C, 8'h00, 8'h20);
        chk("bit_abs", ev(16'h2000, 3'd4, 2'd3, 1'b0, LG, 3'b100, 4'b1101, 2'b10));
        step(8'hA9, 8'h55, 8'h00);
        chk("lda_pre_reset", ev(16'h0201, 3'd1, 2'd2, 1'b0, LD, 3'b100, 4'b1100, 2'b00));
        rst = 1'b1;
        step(8'hA9, 8'h55, 8'h00);
        chk("reset_mid", '0);
        rst = 1'b0;
        step(8'hA9, 8'h55, 8'h00);
        chk("lda_post_reset", ev(16'h0201, 3'd1, 2'd2, 1'b0, LD, 3'b100, 4'b1100, 2'b00));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addr_mode_decoder.md
# addr_mode_decoder

Registered 6502 opcode analysis block. From an opcode, its operand bytes, the current PC and the X/Y index registers, it computes:

- the addressing mode and instruction length;
- the effective address and a page-cross flag;
- an instruction-class and register/flag/memory-usage vector.

It sits between fetch and execute in the CPU core, and drives the addressing and class debug LEDs on the test top.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  8  current opcode.
- pc  in  16  address of the opcode byte.
- operand1 / operand2  in  8 each  bytes at pc+1 / pc+2.
- reg_x / reg_y  in  8 each  index register values.
- effective_addr  out  16  computed address.
- addr_mode  out  3  0 IMP/ACC, 1 IMM, 2 ZP, 3 ZPIDX (zp,X or zp,Y), 4 ABS, 5 ABSIDX (abs,X or abs,Y), 6 IND ((zp,X), (zp),Y, JMP (abs)), 7 REL.
- instruction_length  out  2  byte count, 1..3.
- page_crossed  out  1  indexed or branch page crossing.
- is_load, is_store, is_arithmetic, is_logical, is_shift, is_branch, is_jump, is_transfer, is_compare, is_flag, is_stack  out  1 each  class flags.
- use_reg_a, use_reg_x, use_reg_y  out  1 each  register usage.
- affects_n, affects_z, affects_c, affects_v  out  1 each  status-flag updates.
- mem_read, mem_write  out  1 each  data-memory access.

## Operation
Mode decode uses cc = opcode[1:0] and bbb = opcode[4:2].

- **cc=01:** bbb 0 IND(zp,X), 1 ZP, 2 IMM, 3 ABS, 4 IND(zp),Y, 5 ZP,X, 6 ABS,Y, 7 ABS,X.
- **cc=10:** bbb 0 IMM, 1 ZP, 2 ACC/IMP, 3 ABS, 5 ZP,X, 6 IMP, 7 ABS,X.
  - 96/B6 use ZP,Y; BE uses ABS,Y.
- **cc=00:**
  - A0/C0/E0 are IMM. 00/40/60 are IMP. 20 is ABS.
  - bbb 1 ZP, 2 IMP, 3 ABS (6C is IND), 4 REL, 5 ZP,X, 6 IMP, 7 ABS,X.
- Undefined opcodes (cc=11 and unused slots): IMP, length 1, every flag 0.
- **Length:** IMP 1 (BRK is 1); IMM, ZP, ZPIDX, REL and IND zero-page forms 2; ABS, ABSIDX and 6C 3.

Effective address (all sums wrap):

- **IMP:** 0x0000.
- **IMM:** pc+1.
- **ZP:** {00, op1}.
- **ZPIDX:** {00, (op1+idx) mod 256}.
- **ABS:** {op2, op1}.
- **ABSIDX:** ({op2, op1}+idx) mod 65536.
- **(zp,X):** pointer {00, (op1+X) mod 256}.
- **(zp),Y:** pointer {00, op1}.
- **6C:** pointer {op2, op1}.
- **REL:** pc+2+sign_extend(op1).

page_crossed:

- ABSIDX: carry out of the low-byte add.
- REL: (pc+2)[15:8] differs from target[15:8].
- All other modes: 0.

Classes (each opcode belongs to at most one class; NOP to none):

- **load:** LDA, LDX, LDY.
- **store:** STA, STX, STY.
- **arithmetic:** ADC, SBC, INC, DEC, INX, INY, DEX, DEY.
- **logical:** AND, ORA, EOR, BIT.
- **shift:** ASL, LSR, ROL, ROR.
- **branch:** the 8 Bxx opcodes.
- **jump:** JMP, JSR, RTS, RTI, BRK.
- **transfer:** TAX, TAY, TXA, TYA, TSX, TXS.
- **compare:** CMP, CPX, CPY.
- **flag:** CLC, SEC, CLI, SEI, CLV, CLD, SED.
- **stack:** PHA, PLA, PHP, PLP.

Register usage:

- **use_reg_a:** LDA, STA, ADC, SBC, AND, ORA, EOR, BIT, CMP, TAX, TAY, TXA, TYA, PHA, PLA, and accumulator-mode shifts.
- **use_reg_x:** any instruction naming X as operand or destination, plus every X-indexed mode.
- **use_reg_y:** same rule for Y.

Status-flag effects:

- **affects_n / affects_z:** loads, arithmetic, logical, shifts, compares, transfers except TXS, PLA, PLP, RTI.
- **affects_c:** ADC, SBC, shifts, compares, CLC, SEC, PLP, RTI.
- **affects_v:** ADC, SBC, BIT, CLV, PLP, RTI.

Memory access:

- **mem_read:** load, logical, ADC/SBC, compare, and memory shift/INC/DEC instructions in a memory mode (not IMM/IMP/ACC).
- **mem_write:** stores, and memory-mode shift/INC/DEC (read-modify-write).

## Timing
- All inputs are sampled on a rising clk edge. All outputs are registered and valid one cycle later.
- There is no handshake: a new input set may be applied every cycle, with throughput 1 per cycle.
- Reset: rst high at a rising edge clears every output to 0 on that edge (addr_mode 0, instruction_length 0). rst takes priority over sampling.
- Deasserting rst gives valid outputs one edge after the first non-reset sample.
- Outputs hold their last value while inputs are stable. There is no internal state beyond the output register.

## Test plan
- pc=0x0200, A9 55 -> next cycle: addr_mode 1, length 2, effective_addr 0x0201, is_load=1, use_reg_a=1, affects_n/z=1, mem_read=0.
- X=05, B5 80 -> mode 3, length 2, effective_addr 0x0085, use_reg_x=1, mem_read=1. Then A1 FB -> mode 6, effective_addr 0x0000 (zero-page wrap).
- X=05, BD 34 12 -> mode 5, length 3, effective_addr 0x1239, page_crossed 0. BD FE 12 -> 0x1303, page_crossed 1.
- pc=0x0200: 10 05 -> mode 7, effective_addr 0x0207, page_crossed 0, is_branch. D0 FB -> 0x01FD, page_crossed 1.
- 8D 56 34 -> mode 4, length 3, 0x3456, is_store, mem_write=1. EA -> mode 0, length 1, all class flags 0. 02 -> all flags 0, length 1.
- Drive A9 55, then assert rst for one edge -> all outputs 0 on that edge. Release rst -> valid outputs one cycle later.
